// File: rtl/adventure_player.sv
// adventure_player: queues moves and replays them into a game, reporting win, death or stranding
module adventure_player #(
  parameter int DEPTH = 8,
  parameter int STALL = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dir,
  output logic       cmd_ready,
  input  logic       go,
  input  logic       win,
  input  logic       d,
  output logic       game_reset,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       busy,
  output logic       done,
  output logic       won,
  output logic       died,
  output logic [3:0] moves
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STALL + 1) + 1;
  typedef enum logic [2:0] {IDLE, GRST, PLAY, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [SW-1:0] stall_q;
  logic won_q, died_q;
  logic [3:0] moves_q;
  logic idle_like, push, start, outcome, pop;
  // next state, handshakes and combinational strobes decoded from the queue head
  always_comb begin
    idle_like = state_q == IDLE || state_q == DONE;
    cmd_ready = idle_like && cnt_q != (AW+1)'(DEPTH);
    push = cmd_valid && cmd_ready;
    start = idle_like && go && cnt_q != '0;
    outcome = (state_q == PLAY || state_q == WAIT) && (win || d);
    pop = state_q == PLAY && !win && !d;
    state_d = start ? GRST
            : state_q == GRST ? PLAY
            : outcome ? DONE
            : (pop && cnt_q == (AW+1)'(1)) ? WAIT
            : (state_q == WAIT && stall_q == SW'(STALL - 1)) ? DONE
            : state_q;
    n = pop && mem_q[rd_q] == 2'b00;
    s = pop && mem_q[rd_q] == 2'b01;
    e = pop && mem_q[rd_q] == 2'b10;
    w = pop && mem_q[rd_q] == 2'b11;
    game_reset = state_q == GRST;
    busy = state_q == GRST || state_q == PLAY || state_q == WAIT;
    done = state_q == DONE;
    won = won_q;
    died = died_q;
    moves = moves_q;
  end
  // state, queue pointers, stall timer and run results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      stall_q <= '0;
      won_q <= 1'b0;
      died_q <= 1'b0;
      moves_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= state_q == WAIT ? stall_q + SW'(1) : '0;
      if (outcome) begin
        wr_q <= '0;
        rd_q <= '0;
        cnt_q <= '0;
        won_q <= win && !d;
        died_q <= d;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (start) begin
        won_q <= 1'b0;
        died_q <= 1'b0;
        moves_q <= '0;
      end else if (pop) moves_q <= moves_q + 4'd1;
    end
  end
  // move storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_q] <= cmd_dir;
  end
endmodule

// File: doc/adventure_player.md
ADVENTURE_PLAYER -- requirements
Module: adventure_player

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: move-queue depth in entries, power of two, 2..8.
REQ-002 The block SHALL have parameter STALL, default 2: idle cycles after the last move before a run with no outcome ends.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005 Port cmd_valid SHALL be input, 1 bit: a move is offered on cmd_dir.
REQ-006 Port cmd_dir SHALL be input, 2 bits: move code, 00=N, 01=S, 10=E, 11=W.
REQ-007 Port cmd_ready SHALL be output, 1 bit: the queue accepts a move this cycle.
REQ-008 Port go SHALL be input, 1 bit: start a run with the queued moves.
REQ-009 Ports win and d SHALL be inputs, 1 bit each: game status, win and dead.
REQ-010 Port game_reset SHALL be output, 1 bit: reset pulse to the game.
REQ-011 Ports n, s, e, w SHALL be outputs, 1 bit each: direction strobes to the game.
REQ-012 Port busy SHALL be output, 1 bit: a run is in progress.
REQ-013 Ports done, won, died SHALL be outputs, 1 bit each: run finished, outcome win, outcome death.
REQ-014 Port moves SHALL be output, 4 bits: count of moves issued in the current or last run.

Function
REQ-015 The block SHALL implement the states IDLE, GRST, PLAY, WAIT and DONE.
REQ-016 A move SHALL be pushed when cmd_valid && cmd_ready.
- cmd_ready = (state is IDLE or DONE) && queue not full.
- A push while the queue is full SHALL be impossible and SHALL leave the queue unchanged.
REQ-017 In IDLE or DONE, go with a non-empty queue SHALL move the block to GRST, clear moves, won, died and done, and set busy.
- go with an empty queue SHALL be ignored.
REQ-018 GRST SHALL last exactly 1 cycle with game_reset=1 and n/s/e/w=0, then go to PLAY.
- win and d SHALL be ignored during GRST.
- go at edge k SHALL give game_reset=1 during cycle k+1 and the first strobe during cycle k+2.
REQ-019 In PLAY, if win=0 and d=0, the block SHALL drive exactly one strobe matching the queue head, pop that entry at the edge, and increment moves.
- There SHALL be one move per cycle with no gaps.
- Strobes SHALL decode combinationally from the queue head and state.
REQ-020 In PLAY or WAIT, win=1 or d=1 SHALL drive all strobes to 0 in that same cycle and go to DONE.
- won or died SHALL be latched accordingly.
- Any remaining queue entries SHALL be flushed.
- If win and d are both 1, died=1 and won=0.
REQ-021 When PLAY pops the last entry, the block SHALL go to WAIT.
- WAIT SHALL count STALL cycles with strobes at 0.
- If no outcome occurs within the count, the block SHALL go to DONE with won=0 and died=0 (stranded).
REQ-022 In DONE, done SHALL be 1, busy SHALL be 0, and won, died and moves SHALL hold until the next accepted go.
REQ-023 The queue SHALL wrap its pointers modulo DEPTH and track the occupancy count with one extra bit, so full and empty are never ambiguous.
REQ-024 moves SHALL never exceed DEPTH and SHALL not wrap.
REQ-025 At most one of n, s, e, w SHALL be 1 in any cycle, and a strobe SHALL be 1 only in PLAY.

Reset
REQ-026 When reset=1 at an edge, the block SHALL enter IDLE from any state, including mid-run, and empty the queue.
- Outputs after that edge SHALL be: n=s=e=w=0, game_reset=0, busy=0, done=0, won=0, died=0, moves=0, cmd_ready=1.
REQ-027 reset SHALL take priority over go and over cmd_valid in the same cycle.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- V1: push E,S,E; pulse go; connect adventure_game -> game_reset for 1 cycle, then e,s,e strobes on consecutive cycles, then died=1, won=0, moves=3, done=1.
- V2: push N,W; a stub game asserts win in the cycle after the first strobe -> only the n strobe is issued, won=1, moves=1, queue empty, cmd_ready=1.
- V3: push DEPTH=8 moves -> cmd_ready=0 after the 8th push and a 9th push is dropped; run with stub win=d=0 -> 8 strobes, then 2 WAIT cycles, done=1, won=died=0, moves=8.
- V4: stub raises win=1 and d=1 together during PLAY -> died=1, won=0, strobes 0 in that cycle.
- V5: assert reset during PLAY after 2 strobes -> next cycle all outputs at reset values, queue empty, and a following go is ignored.
- V6: go with an empty queue -> no game_reset pulse, state stays IDLE; a go raised simultaneously with the first push is also ignored.
